// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - sequences an N-bit shift register through multi-bit shift/rotate commands.
// Optional SHSEQ_ABORT_EN adds Abort input and Aborted output.
module shift_sequencer #(
    parameter int N  = 8,
    parameter int AW = 4
) (
    input  logic          Clock,
    input  logic          Reset,
`ifdef SHSEQ_ABORT_EN
    input  logic          Abort,
    output logic          Aborted,
`endif
    input  logic          Start,
    input  logic [2:0]    Op,
    input  logic [AW-1:0] Amount,
    input  logic [N-1:0]  Data,
    output logic          Ready,
    output logic          Done,
    output logic          Carry,
    output logic          Error,
    output logic [1:0]    RegMode,
    output logic          RegCIn,
    output logic [N-1:0]  RegInput,
    input  logic          RegCOut,
    input  logic [N-1:0]  RegOutput
);

    localparam logic [2:0] OP_LSL = 3'd0;
    localparam logic [2:0] OP_LSR = 3'd1;
    localparam logic [2:0] OP_ASR = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    localparam logic [1:0] MODE_KEEP = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_FINISH} state_t;

    state_t        state, state_next;
    logic [2:0]    op_q;
    logic [AW-1:0] amt_q;
    logic [AW-1:0] count;
    logic [N-1:0]  data_q;
    logic          op_legal;
    logic          abort_req;

    assign op_legal = (Op <= OP_ROR);
    assign RegInput = data_q;

`ifdef SHSEQ_ABORT_EN
    logic abort_pend;
    assign abort_req = Abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_next = state;
        Ready      = 1'b0;
        RegMode    = MODE_KEEP;
        RegCIn     = 1'b0;
        case (state)
            S_IDLE: begin
                Ready = 1'b1;
                if (Start && op_legal)
                    state_next = S_LOAD;
            end
            S_LOAD: begin
                RegMode    = MODE_LOAD;
                state_next = (amt_q != '0 && !abort_req) ? S_SHIFT : S_FINISH;
            end
            S_SHIFT: begin
                RegMode = (op_q == OP_LSL || op_q == OP_ROL) ? MODE_SHL : MODE_SHR;
                // Fill bit follows the live register output so each step is correct.
                case (op_q)
                    OP_ASR, OP_ROL: RegCIn = RegOutput[N-1];
                    OP_ROR:         RegCIn = RegOutput[0];
                    default:        RegCIn = 1'b0;
                endcase
                if (count == AW'(1) || abort_req)
                    state_next = S_FINISH;
            end
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            amt_q      <= '0;
            data_q     <= '0;
            count      <= '0;
            Done       <= 1'b0;
            Carry      <= 1'b0;
            Error      <= 1'b0;
`ifdef SHSEQ_ABORT_EN
            abort_pend <= 1'b0;
            Aborted    <= 1'b0;
`endif
        end else begin
            state <= state_next;
            Done  <= 1'b0;
            Error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start && op_legal) begin
                        op_q   <= Op;
                        amt_q  <= Amount;
                        data_q <= Data;
                        Carry  <= 1'b0;
`ifdef SHSEQ_ABORT_EN
                        abort_pend <= 1'b0;
                        Aborted    <= 1'b0;
`endif
                    end else if (Start) begin
                        Error <= 1'b1;
                    end
                end
                S_LOAD: begin
                    count <= amt_q;
`ifdef SHSEQ_ABORT_EN
                    if (Abort) abort_pend <= 1'b1;
`endif
                end
                S_SHIFT: begin
                    count <= count - AW'(1);
`ifdef SHSEQ_ABORT_EN
                    if (Abort) abort_pend <= 1'b1;
`endif
                end
                S_FINISH: begin
                    Done  <= 1'b1;
                    Carry <= RegCOut;
`ifdef SHSEQ_ABORT_EN
                    Aborted <= abort_pend;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with a behavioural register.
module tb_shift_sequencer;
    localparam int N  = 8;
    localparam int AW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Start;
    logic [2:0]    Op;
    logic [AW-1:0] Amount;
    logic [N-1:0]  Data;
    logic          Ready, Done, Carry, Error;
    logic [1:0]    RegMode;
    logic          RegCIn;
    logic [N-1:0]  RegInput;
    logic          RegCOut;
    logic [N-1:0]  RegOutput;
`ifdef SHSEQ_ABORT_EN
    logic          Abort;
    logic          Aborted;
`endif

    int passed = 0;
    int total  = 0;

    shift_sequencer #(.N(N), .AW(AW)) dut (
        .Clock(Clock), .Reset(Reset),
`ifdef SHSEQ_ABORT_EN
        .Abort(Abort), .Aborted(Aborted),
`endif
        .Start(Start), .Op(Op), .Amount(Amount), .Data(Data),
        .Ready(Ready), .Done(Done), .Carry(Carry), .Error(Error),
        .RegMode(RegMode), .RegCIn(RegCIn), .RegInput(RegInput),
        .RegCOut(RegCOut), .RegOutput(RegOutput)
    );

    always #5 Clock = ~Clock;

    // Controlled datapath register; COut holds the most recent bit shifted out.
    logic [N-1:0] reg_q    = '0;
    logic         reg_cout = 1'b0;
    assign RegOutput = reg_q;
    assign RegCOut   = reg_cout;
    always @(posedge Clock) begin
        case (RegMode)
            2'b01: begin reg_q <= RegInput; reg_cout <= 1'b0; end
            2'b10: begin reg_q <= {reg_q[N-2:0], RegCIn}; reg_cout <= reg_q[N-1]; end
            2'b11: begin reg_q <= {RegCIn, reg_q[N-1:1]}; reg_cout <= reg_q[0]; end
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void ref_model(input int op, input int amt, input logic [7:0] d,
                                      output logic [7:0] r, output logic c);
        int x, y, k;
        c = 1'b0;
        r = 8'h00;
        k = amt % N;
        case (op)
            0: begin x = int'(d); y = x << amt; r = 8'(y); if (amt > 0) c = y[8]; end
            1: begin x = int'(d); r = 8'(x >> amt); if (amt > 0) begin y = x >> (amt - 1); c = y[0]; end end
            2: begin x = int'($signed(d)); r = 8'(x >>> amt); if (amt > 0) begin y = x >>> (amt - 1); c = y[0]; end end
            3: begin x = int'(d); r = 8'((x << k) | (x >> (N - k))); if (amt > 0) c = r[0]; end
            4: begin x = int'(d); r = 8'((x >> k) | (x << (N - k))); if (amt > 0) c = r[N-1]; end
            default: ;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input int amt, input logic [7:0] d,
                           output int lat, output int shifts, output int loads,
                           output int wrongdir, output bit busy);
        int waitc = 0;
        logic [1:0] dir;
        dir = (op == 3'd0 || op == 3'd3) ? 2'b10 : 2'b11;
        while (!Ready && waitc < 50) begin @(posedge Clock); #1; waitc++; end
        if (!Ready) check("ready_wait", 32'(Ready), 32'd1);
        Start = 1'b1; Op = op; Amount = AW'(amt); Data = d;
        @(posedge Clock); #1;
        Start = 1'b0; Op = 3'($urandom); Amount = AW'($urandom); Data = 8'($urandom);
        lat = 1; shifts = 0; loads = 0; wrongdir = 0; busy = !Ready;
        while (!Done && lat < 40) begin
            if (RegMode == 2'b01) loads++;
            if (RegMode[1]) begin shifts++; if (RegMode != dir) wrongdir++; end
            @(posedge Clock); #1; lat++;
        end
    endtask

    typedef struct {
        logic [2:0] op;
        int         amt;
        logic [7:0] data;
        logic [7:0] exp_res;
        logic       exp_c;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_and_check(input string tag, input logic [2:0] op, input int amt,
                                 input logic [7:0] d, input logic [7:0] er, input logic ec);
        int lat, sh, ld, wd;
        bit busy;
        run_cmd(op, amt, d, lat, sh, ld, wd, busy);
        check({tag, "_latency"}, 32'(lat), 32'(amt + 3));
        check({tag, "_result"}, 32'(RegOutput), 32'(er));
        check({tag, "_carry"}, 32'(Carry), 32'(ec));
        check({tag, "_shifts"}, 32'(sh), 32'(amt));
        check({tag, "_loads"}, 32'(ld), 32'd1);
        check({tag, "_dir"}, 32'(wd), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int dones, bad;
        logic [7:0] res, r;
        logic c;

        vecs[0] = '{3'd0, 1,  8'h81, 8'h02, 1'b1, 4};
        vecs[1] = '{3'd2, 3,  8'h80, 8'hF0, 1'b0, 6};
        vecs[2] = '{3'd4, 9,  8'h01, 8'h80, 1'b1, 12};
        vecs[3] = '{3'd1, 0,  8'h5A, 8'h5A, 1'b0, 3};
        vecs[4] = '{3'd0, 10, 8'hFF, 8'h00, 1'b0, 13};
        vecs[5] = '{3'd2, 12, 8'h80, 8'hFF, 1'b1, 15};
        vecs[6] = '{3'd3, 1,  8'h81, 8'h03, 1'b1, 4};
        vecs[7] = '{3'd1, 8,  8'h81, 8'h00, 1'b1, 11};

        Reset = 1'b1; Start = 1'b0; Op = '0; Amount = '0; Data = '0;
`ifdef SHSEQ_ABORT_EN
        Abort = 1'b0;
`endif
        @(posedge Clock); @(posedge Clock); #1;
        Reset = 1'b0;
        #1;
        check("rst_ready", 32'(Ready), 32'd1);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_carry", 32'(Carry), 32'd0);
        check("rst_error", 32'(Error), 32'd0);
        check("rst_mode", 32'(RegMode), 32'd0);
        check("rst_cin", 32'(RegCIn), 32'd0);
        check("rst_input", 32'(RegInput), 32'd0);
        @(posedge Clock); #1;

        // Back-to-back table: each command starts in the previous Done cycle.
        for (int i = 0; i < 8; i++) begin
            int lat, sh, ld, wd;
            bit busy;
            run_cmd(vecs[i].op, vecs[i].amt, vecs[i].data, lat, sh, ld, wd, busy);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_result", i), 32'(RegOutput), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 32'(Carry), 32'(vecs[i].exp_c));
            check($sformatf("vec%0d_shifts", i), 32'(sh), 32'(vecs[i].amt));
            check($sformatf("vec%0d_loads", i), 32'(ld), 32'd1);
            check($sformatf("vec%0d_dir", i), 32'(wd), 32'd0);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
        end

        // Done lasts one cycle; Carry holds afterwards.
        run_and_check("hold", 3'd0, 1, 8'h81, 8'h02, 1'b1);
        @(posedge Clock); #1;
        check("done_one_cycle", 32'(Done), 32'd0);
        @(posedge Clock); #1; @(posedge Clock); #1;
        check("carry_held", 32'(Carry), 32'd1);
        check("idle_ready", 32'(Ready), 32'd1);

        // Start re-pulsed while busy is ignored.
        Start = 1'b1; Op = 3'd2; Amount = AW'(3); Data = 8'h80;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("accept_clears_carry", 32'(Carry), 32'd0);
        dones = 0; res = 8'h00;
        for (int i = 1; i < 20; i++) begin
            if (i == 3) begin Start = 1'b1; Op = 3'd0; Amount = AW'(1); Data = 8'h55; end
            if (i == 4) Start = 1'b0;
            if (Done) begin dones++; res = RegOutput; end
            @(posedge Clock); #1;
        end
        check("repulse_dones", 32'(dones), 32'd1);
        check("repulse_result", 32'(res), 32'hF0);
        check("repulse_carry", 32'(Carry), 32'd0);

        // Illegal opcode.
        Start = 1'b1; Op = 3'd7; Amount = AW'(3); Data = 8'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("illegal_error", 32'(Error), 32'd1);
        check("illegal_mode", 32'(RegMode), 32'd0);
        check("illegal_ready", 32'(Ready), 32'd1);
        check("illegal_done", 32'(Done), 32'd0);
        @(posedge Clock); #1;
        check("illegal_error_pulse", 32'(Error), 32'd0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (Done || RegMode != 2'b00 || !Ready) bad++;
            @(posedge Clock); #1;
        end
        check("illegal_quiet", 32'(bad), 32'd0);

        // Reset in the middle of a rotate.
        run_and_check("pre_rst", 3'd0, 1, 8'h81, 8'h02, 1'b1);
        Start = 1'b1; Op = 3'd3; Amount = AW'(5); Data = 8'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1; @(posedge Clock); #1; @(posedge Clock); #1;
        check("mid_shifting", 32'(RegMode), 32'd2);
        Reset = 1'b1; #1;
        check("midrst_mode", 32'(RegMode), 32'd0);
        check("midrst_ready", 32'(Ready), 32'd1);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_carry", 32'(Carry), 32'd0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (Done) dones++;
            @(posedge Clock); #1;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        check("midrst_carry_low", 32'(Carry), 32'd0);

`ifdef SHSEQ_ABORT_EN
        Start = 1'b1; Op = 3'd3; Amount = AW'(5); Data = 8'hFF;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1; @(posedge Clock); #1; @(posedge Clock); #1;
        Abort = 1'b1;
        @(posedge Clock); #1;
        Abort = 1'b0;
        check("abort_no_early_flag", 32'(Aborted), 32'd0);
        @(posedge Clock); #1;
        check("abort_done", 32'(Done), 32'd1);
        check("abort_flag", 32'(Aborted), 32'd1);
        check("abort_result", 32'(RegOutput), 32'hFF);
        run_and_check("post_abort", 3'd1, 2, 8'h0C, 8'h03, 1'b0);
        check("aborted_cleared", 32'(Aborted), 32'd0);
`endif

        // Randomised commands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            int op, amt;
            logic [7:0] d;
            op  = int'($urandom_range(0, 4));
            amt = int'($urandom_range(0, 15));
            d   = 8'($urandom);
            ref_model(op, amt, d, r, c);
            run_and_check($sformatf("rnd%0d", i), 3'(op), amt, d, r, c);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
